// File: rtl/serial_link_seq.sv
// serial_link_seq: request-driven load/shift/latch sequencer for a serial shift-register link
module serial_link_seq #(
    parameter int WIDTH = 4,
    parameter int DIV   = 16,
    parameter int DIV_W = 5,
    parameter int CNT_W = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ,
    output logic             LDIN,
    output logic             SHIFT_EN,
    output logic             LDOUT,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] BIT_CNT
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] LATCH = 3'd3;
    localparam logic [2:0] FIN   = 3'd4;
    logic [2:0]       state;
    logic [DIV_W-1:0] div;
    logic             armed;
    logic             tick;
    assign tick = state == SHIFT && div == DIV_W'(DIV - 1);
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            div     <= '0;
            BIT_CNT <= '0;
            armed   <= 1'b0;
        end else begin
            armed <= !REQ || (armed && state != IDLE);
            case (state)
                IDLE: if (REQ && armed) begin
                    state   <= LOAD;
                    div     <= '0;
                    BIT_CNT <= '0;
                end
                LOAD: state <= SHIFT;
                SHIFT: begin
                    div     <= tick ? '0 : div + 1'b1;
                    BIT_CNT <= BIT_CNT + CNT_W'(tick);
                    if (tick && BIT_CNT == CNT_W'(WIDTH - 1)) state <= LATCH;
                end
                LATCH: state <= FIN;
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    always_comb begin
        LDIN     = state == LOAD;
        SHIFT_EN = tick;
        LDOUT    = state == LATCH;
        DONE     = state == FIN;
        BUSY     = state == LOAD || state == SHIFT || state == LATCH || state == FIN;
    end
endmodule

// File: tb/tb_serial_link_seq.sv
// tb_serial_link_seq: directed table, corner sequences and random REQ/RST against a timing model
module tb_serial_link_seq;
    localparam int W = 4;
    logic clk = 1'b0, rst = 1'b1, req = 1'b0;
    always #5 clk = ~clk;
    logic [1:0] ldin, shen, ldout, busy, done;
    logic [2:0] cnt3, cnt1;
    serial_link_seq #(.WIDTH(W), .DIV(3), .DIV_W(5), .CNT_W(3)) u3 (
        .CLK(clk), .RST(rst), .REQ(req), .LDIN(ldin[0]), .SHIFT_EN(shen[0]),
        .LDOUT(ldout[0]), .BUSY(busy[0]), .DONE(done[0]), .BIT_CNT(cnt3));
    serial_link_seq #(.WIDTH(W), .DIV(1), .DIV_W(2), .CNT_W(3)) u1 (
        .CLK(clk), .RST(rst), .REQ(req), .LDIN(ldin[1]), .SHIFT_EN(shen[1]),
        .LDOUT(ldout[1]), .BUSY(busy[1]), .DONE(done[1]), .BIT_CNT(cnt1));

    // shift registers hung on the DIV=3 instance
    logic [3:0] src = 4'b1011, tx, rx, par, sent;
    always @(posedge clk) begin
        if (ldin[0]) begin
            tx   <= src;
            sent <= src;
        end else if (shen[0]) begin
            tx <= {tx[2:0], 1'b0};
            rx <= {rx[2:0], tx[3]};
        end
        if (ldout[0]) par <= rx;
    end

    int checks = 0, errors = 0;
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // model: a transfer is "cycles since accept" t; every strobe is a rule on t
    int divs[2] = '{3, 1};
    bit m_act[2], m_arm[2];
    int m_t[2], m_held[2];
    function automatic void m_step(int i, bit r, bit q);
        bit acc = 0;
        if (r) begin
            m_act[i] = 0; m_arm[i] = 0; m_held[i] = 0;
            return;
        end
        if (m_act[i]) begin
            if (m_t[i] == 3 + W * divs[i]) begin
                m_act[i] = 0;
                m_held[i] = W;
            end else m_t[i]++;
        end else if (q && m_arm[i]) begin
            m_act[i] = 1; m_t[i] = 1; acc = 1;
        end
        if (!q) m_arm[i] = 1;
        else if (acc) m_arm[i] = 0;
    endfunction
    function automatic logic [7:0] m_out(int i);
        int t = m_t[i], d = divs[i], c;
        bit a = m_act[i], ld, sh, lo, dn;
        ld = a && t == 1;
        sh = a && t >= 1 + d && t <= 1 + W * d && (t - 1) % d == 0;
        lo = a && t == 2 + W * d;
        dn = a && t == 3 + W * d;
        c = !a ? m_held[i] : (t < 2 ? 0 : ((t - 2) / d > W ? W : (t - 2) / d));
        return {ld, sh, lo, a, dn, c[2:0]};
    endfunction
    function automatic logic [7:0] dut_out(int i);
        return {ldin[i], shen[i], ldout[i], busy[i], done[i], i == 0 ? cnt3 : cnt1};
    endfunction

    // drive inputs for the current cycle, advance one edge, compare both instances with the model
    task automatic step(bit r, bit q);
        logic [7:0] e;
        rst = r;
        req = q;
        @(posedge clk);
        m_step(0, r, q);
        m_step(1, r, q);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            e = m_out(i);
            chk(i == 0 ? "model_div3" : "model_div1", dut_out(i), e);
            chk("strobe_excl", 32'(ldin[i]) + 32'(shen[i]) + 32'(ldout[i]) <= 1, 1);
            if (i == 0 && e[3]) begin
                chk("rx_word", par, sent);
                src = 4'($urandom);
            end
        end
    endtask

    typedef struct {
        int c;
        bit r;
        bit q;
        logic [7:0] e;
    } vec_t;
    function automatic vec_t mk(int c, bit r, bit q, logic [7:0] e);
        vec_t v;
        v.c = c; v.r = r; v.q = q; v.e = e;
        return v;
    endfunction

    initial begin
        vec_t tab[$];
        int k = 0, n;
        bit r = 1, q = 0;
        logic [6:0] sh_s, lo_s, dn_s, bz_s;
        // {LDIN,SHIFT_EN,LDOUT,BUSY,DONE,BIT_CNT} seen in cycle c; inputs applied from c on
        tab.push_back(mk(0,  1, 0, 8'b00000_000));
        tab.push_back(mk(1,  1, 0, 8'b00000_000));
        tab.push_back(mk(2,  0, 0, 8'b00000_000));
        tab.push_back(mk(9,  0, 0, 8'b00000_000));
        tab.push_back(mk(10, 0, 1, 8'b00000_000));
        tab.push_back(mk(11, 0, 1, 8'b10010_000));
        tab.push_back(mk(13, 0, 1, 8'b00010_000));
        tab.push_back(mk(14, 0, 1, 8'b01010_000));
        tab.push_back(mk(15, 0, 1, 8'b00010_001));
        tab.push_back(mk(17, 0, 1, 8'b01010_001));
        tab.push_back(mk(20, 0, 1, 8'b01010_010));
        tab.push_back(mk(23, 0, 1, 8'b01010_011));
        tab.push_back(mk(24, 0, 1, 8'b00110_100));
        tab.push_back(mk(25, 0, 1, 8'b00011_100));
        tab.push_back(mk(26, 0, 1, 8'b00000_100));
        tab.push_back(mk(27, 0, 1, 8'b00000_100));
        for (int c = 0; c <= 27; c++) begin
            if (k < tab.size() && tab[k].c == c) begin
                r = tab[k].r;
                q = tab[k].q;
                if (c > 0) chk($sformatf("table_c%0d", c), dut_out(0), tab[k].e);
                k++;
            end
            step(r, q);
        end
        chk("rx_1011", par, 4'b1011);

        // REQ held high after a transfer must not restart
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 1);
            n += int'(ldin[0]) + int'(ldin[1]);
        end
        chk("held_req_no_ldin", n, 0);

        // one low cycle re-arms; both instances accept together
        step(0, 0);
        step(0, 1);
        chk("reaccept_ldin_div3", ldin[0], 1);
        chk("reaccept_ldin_div1", ldin[1], 1);
        for (int i = 0; i < 7; i++) begin
            step(0, 1);
            sh_s[6-i] = shen[1];
            lo_s[6-i] = ldout[1];
            dn_s[6-i] = done[1];
            bz_s[6-i] = busy[1];
        end
        chk("div1_shift_seq", sh_s, 7'b1111000);
        chk("div1_ldout_seq", lo_s, 7'b0000100);
        chk("div1_done_seq", dn_s, 7'b0000010);
        chk("div1_busy_seq", bz_s, 7'b1111110);
        n = 7;
        while (!done[0] && n < 40) begin
            step(0, 1);
            n++;
        end
        chk("div3_ldin_to_done", n, 2 + W * 3);

        // reset mid-transfer aborts; REQ still high cannot restart
        step(0, 0);
        step(0, 1);
        for (int i = 0; i < 6; i++) step(0, 1);
        chk("pre_abort_busy", busy[0], 1);
        step(1, 1);
        chk("abort_outputs_div3", dut_out(0), 8'h00);
        chk("abort_outputs_div1", dut_out(1), 8'h00);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step(0, 1);
            n += int'(ldin[0]) + int'(ldout[0]) + int'(done[0]) + int'(busy[0]) + int'(ldin[1]);
        end
        chk("no_restart_after_reset", n, 0);

        // REQ rising together with reset is dropped
        step(0, 0);
        step(1, 1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 1);
            n += int'(ldin[0]) + int'(shen[0]) + int'(ldout[0]) + int'(ldin[1]);
        end
        chk("req_with_reset_dropped", n, 0);

        // random REQ activity with rare resets
        q = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) q = !q;
            step($urandom_range(0, 199) == 0, q);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
